// File: rtl/alu_seq_exec.sv
// Multi-cycle integer ALU: single-cycle logic/arith/compare ops, 1-bit-per-cycle serial shifter.
// Valid/ready handshake on both sides; one op in flight at a time.
module alu_seq_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1010;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_t;

  state_t state, state_next;
  shift_t shift_kind, shift_kind_next;

  logic [WIDTH-1:0]   result_reg, shreg, alu_out, shift_step;
  logic [SHAMT_W-1:0] cnt, shamt;
  logic               zero_reg, illegal_reg, alu_illegal, is_shift, last_shift;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign illegal   = illegal_reg;

  assign shamt      = op_b[SHAMT_W-1:0];
  assign last_shift = (cnt == SHAMT_W'(1));

  // Single-cycle ops and shift-kind decode.
  always_comb begin
    alu_out         = '0;
    alu_illegal     = 1'b0;
    is_shift        = 1'b0;
    shift_kind_next = SH_LL;
    case (control)
      OP_AND:  alu_out = op_a & op_b;
      OP_OR:   alu_out = op_a | op_b;
      OP_XOR:  alu_out = op_a ^ op_b;
      OP_ADD:  alu_out = op_a + op_b;
      OP_SUB:  alu_out = op_a - op_b;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_SLL:  begin is_shift = 1'b1; shift_kind_next = SH_LL; end
      OP_SRL:  begin is_shift = 1'b1; shift_kind_next = SH_RL; end
      OP_SRA:  begin is_shift = 1'b1; shift_kind_next = SH_RA; end
      default: alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    shift_step = shreg;
    case (shift_kind)
      SH_LL:   shift_step = {shreg[WIDTH-2:0], 1'b0};
      SH_RL:   shift_step = {1'b0, shreg[WIDTH-1:1]};
      SH_RA:   shift_step = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
      default: shift_step = shreg;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = (is_shift && shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Result/flags only change on the edge that enters DONE, so they hold through any stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      shreg       <= '0;
      cnt         <= '0;
      shift_kind  <= SH_LL;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (is_shift) begin
            shreg      <= op_a;
            cnt        <= shamt;
            shift_kind <= shift_kind_next;
            if (shamt == '0) begin
              result_reg  <= op_a;
              zero_reg    <= (op_a == '0);
              illegal_reg <= 1'b0;
            end
          end else begin
            result_reg  <= alu_out;
            zero_reg    <= (alu_out == '0);
            illegal_reg <= alu_illegal;
          end
        end
        SHIFT: begin
          shreg <= shift_step;
          cnt   <= cnt - SHAMT_W'(1);
          if (last_shift) begin
            result_reg  <= shift_step;
            zero_reg    <= (shift_step == '0);
            illegal_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed-vector bench for alu_seq_exec: hand-computed results, latencies,
// backpressure hold and mid-shift reset.
module tb_alu_seq_exec;

  localparam int W = 32;
  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SLL = 4'b0011,
                         C_SLT = 4'b0100, C_SLTU = 4'b0101, C_SUB = 4'b0110, C_XOR = 4'b0111,
                         C_SRL = 4'b1000, C_SRA = 4'b1010;

  logic         clk, reset, in_valid, in_ready, out_valid, out_ready, zero, illegal, busy;
  logic [3:0]   control;
  logic [W-1:0] op_a, op_b, result;

  int   total = 0;
  int   bad   = 0;
  logic seen_v;

  alu_seq_exec #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .control(control), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One op with out_ready held high; latency counted in cycles from the accept edge.
  task automatic do_op(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z,
                       input logic exp_il, input int exp_lat);
    int   lat;
    logic seen;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; control = ctl; op_a = a; op_b = b; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; control = 4'b0; op_a = '0; op_b = '0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      seen = out_valid;
    end
    check({tag, "_valid"},   32'(out_valid), 32'd1);
    check({tag, "_latency"}, 32'(lat),       32'(exp_lat));
    check({tag, "_result"},  result,         exp_r);
    check({tag, "_zero"},    32'(zero),      32'(exp_z));
    check({tag, "_illegal"}, 32'(illegal),   32'(exp_il));
    $display("op %s ctl=%b a=%h b=%h -> result=%h zero=%0b illegal=%0b latency=%0d",
             tag, ctl, a, b, result, zero, illegal, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    control = 4'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_result",    result,          32'd0);
    check("rst_zero",      32'(zero),       32'd0);
    check("rst_illegal",   32'(illegal),    32'd0);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_busy",      32'(busy),       32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),   32'd1);
    $display("reset released");

    do_op("add",      C_ADD,  32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1);
    do_op("sub_eq",   C_SUB,  32'h3,          32'h3,          32'h0,          1'b1, 1'b0, 1);
    do_op("sub_wrap", C_SUB,  32'h0,          32'h1,          32'hFFFF_FFFF,  1'b0, 1'b0, 1);
    do_op("and",      C_AND,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1'b0, 1);
    do_op("or",       C_OR,   32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  1'b0, 1'b0, 1);
    do_op("xor",      C_XOR,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0,  1'b0, 1'b0, 1);
    do_op("sll31",    C_SLL,  32'h1,          32'd31,         32'h8000_0000,  1'b0, 1'b0, 32);
    do_op("sll_b25",  C_SLL,  32'h1,          32'h25,         32'h0000_0020,  1'b0, 1'b0, 6);
    do_op("sll1",     C_SLL,  32'h8000_0001,  32'd1,          32'h0000_0002,  1'b0, 1'b0, 2);
    do_op("sra4",     C_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 1'b0, 5);
    do_op("srl4",     C_SRL,  32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 1'b0, 5);
    do_op("srl3",     C_SRL,  32'hF000_0001,  32'd3,          32'h1E00_0000,  1'b0, 1'b0, 4);
    do_op("sra_pos",  C_SRA,  32'h7000_0000,  32'd2,          32'h1C00_0000,  1'b0, 1'b0, 3);
    do_op("sra0",     C_SRA,  32'h1234_5678,  32'h0000_0100,  32'h1234_5678,  1'b0, 1'b0, 1);
    do_op("srl_zero", C_SRL,  32'h0000_0001,  32'd1,          32'h0,          1'b1, 1'b0, 2);
    do_op("slt",      C_SLT,  32'hFFFF_FFFF,  32'h1,          32'h1,          1'b0, 1'b0, 1);
    do_op("sltu",     C_SLTU, 32'hFFFF_FFFF,  32'h1,          32'h0,          1'b1, 1'b0, 1);
    do_op("slt_rev",  C_SLT,  32'h1,          32'hFFFF_FFFF,  32'h0,          1'b1, 1'b0, 1);
    do_op("sltu_rev", C_SLTU, 32'h1,          32'hFFFF_FFFF,  32'h1,          1'b0, 1'b0, 1);
    do_op("ill_1111", 4'b1111, 32'h5,         32'h7,          32'h0,          1'b1, 1'b1, 1);
    do_op("add_clr",  C_ADD,  32'hFFFF_FFFF,  32'h2,          32'h1,          1'b0, 1'b0, 1);

    // Backpressure: hold DONE for 3 cycles while a competing request is presented.
    @(negedge clk);
    in_valid = 1'b1; control = C_ADD; op_a = 32'h10; op_b = 32'h20; out_ready = 1'b0;
    @(posedge clk); #1;
    control = C_SUB; op_a = 32'h5; op_b = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_result",    result,         32'h30);
      check("bp_zero",      32'(zero),      32'd0);
    end
    $display("op backpressure add 10+20 -> result=%h held 3 cycles", result);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready),  32'd1);
    check("bp_release_hold",  result,         32'h30);

    do_op("ill_1001", 4'b1001, 32'h1,         32'h1,          32'h0,          1'b1, 1'b1, 1);

    // Reset pulse mid-shift discards the op.
    @(negedge clk);
    in_valid = 1'b1; control = C_SLL; op_a = 32'h1; op_b = 32'd20; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy",      32'(busy),      32'd1);
    check("mid_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    #2;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_busy",      32'(busy),      32'd0);
    check("mr_result",    result,         32'd0);
    check("mr_zero",      32'(zero),      32'd0);
    check("mr_illegal",   32'(illegal),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_v = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen_v = 1'b1;
    end
    check("mr_no_valid",  32'(seen_v),   32'd0);
    check("mr_in_ready",  32'(in_ready), 32'd1);
    $display("op sll 1 by 20 aborted by reset, result=%h", result);

    do_op("recover", C_ADD, 32'h100, 32'h23, 32'h123, 1'b0, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
